// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: loader states and stream framing.
// Optional checksum byte after the data words is enabled by PROG_LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/byte_packer.sv
// Four-byte little-endian shift assembler. word_ready marks the accepted byte
// that completes a word; word then already holds the complete 32-bit value.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  cnt;
  logic [23:0] sh;

  // shift each accepted byte in from the top so the first byte ends up lowest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else if (take) begin
      cnt <= cnt + 2'd1;
      sh  <= {in_data, sh[23:8]};
    end
  end

  // completed word combines the three held bytes with the byte on the bus
  always_comb begin
    word       = {in_data, sh};
    word_ready = take && (cnt == LAST_IDX);
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a word count followed by that many
// little-endian 32-bit words and writes them into instruction memory while
// holding the CPU in reset. Optional trailing XOR checksum byte is enabled by
// defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [32:0]       MAX_WORDS = 33'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   REM_ONE   = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_FIN = ST_CSUM;
`else
  localparam state_t ST_FIN = ST_DONE;
`endif

  state_t          state;
  state_t          state_nxt;
  logic            rdy_en;
  logic            accept;
  logic            take;
  logic [31:0]     word;
  logic            word_ready;
  logic [ADDR_W:0] remaining;
  logic            last_pulse;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign accept = in_valid && in_ready;
  assign take   = accept && ((state == ST_HDR) || (state == ST_DATA));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .take       (take),
    .in_data    (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HDR;
    else     state <= state_nxt;
  end

  // in_ready stays low through reset and rises on the first edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // next-state and status outputs; input is refused during the final write pulse
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_HDR: begin
        in_ready = rdy_en;
        if (word_ready) begin
          if ({1'b0, word} > MAX_WORDS) state_nxt = ST_ERR;
          else if (word == 32'd0)      state_nxt = ST_FIN;
          else                         state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = rdy_en && !last_pulse;
        if (im_we && last_pulse) state_nxt = ST_FIN;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = rdy_en;
        if (accept) state_nxt = (in_data == csum) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERR: begin
        err = 1'b1;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  // word count capture, write strobe generation and address advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      remaining  <= '0;
      last_pulse <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (im_we) im_addr <= im_addr + ADDR_ONE;
      if ((state == ST_HDR) && word_ready) remaining <= word[ADDR_W:0];
      if ((state == ST_DATA) && word_ready) begin
        im_we      <= 1'b1;
        im_wdata   <= word;
        remaining  <= remaining - REM_ONE;
        last_pulse <= (remaining == REM_ONE);
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // running XOR over data bytes only; header bytes are excluded
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               csum <= '0;
    else if ((state == ST_DATA) && take)   csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as bytes are
// driven and popped by a monitor whenever the loader strobes im_we.
module tb_prog_loader;

  localparam int ADDR_W = 7;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] words[$];
  bit          gaps = 1'b0;
  int          gp_idx = 0;
  bit          pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  bit          prev_we = 1'b0;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // write monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_we <= 1'b0;
    end else begin
      prev_we <= im_we;
      if (im_we) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%h (no write expected)", im_addr, im_wdata);
        end else begin
          got = sb.pop_front();
          if (im_addr !== got.addr || im_wdata !== got.data) begin
            failures++;
            $display("FAIL write_value addr=%0d data=%h expected addr=%0d data=%h",
                     im_addr, im_wdata, got.addr, got.data);
          end
          checks++;
          if (cpu_hold !== 1'b1 || prev_we !== 1'b0) begin
            failures++;
            $display("FAIL write_pulse cpu_hold=%b prev_we=%b expected cpu_hold=1 prev_we=0",
                     cpu_hold, prev_we);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // offer one byte starting at a negedge; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    bit rs;
    bit ok;
    if (gaps) begin
      while (pat[gp_idx] == 1'b0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        gp_idx   = (gp_idx + 1) % 7;
        @(negedge clk);
      end
      gp_idx = (gp_idx + 1) % 7;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rs = in_ready;
      @(negedge clk);
      if (rs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h in_ready=%b expected in_ready=1", b, in_ready);
    end
  endtask

  task automatic send_header(input logic [31:0] n);
    logic [31:0] v;
    v = n;
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8]);
  endtask

  // header n, then all entries of words[], then (if enabled) checksum ^ flip
  task automatic stream_load(input logic [31:0] n, input logic [7:0] flip);
    logic [7:0]  cs;
    logic [31:0] w;
    exp_t        e;
    cs = 8'h00;
    send_header(n);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        if (k == 3) begin
          e.addr = ADDR_W'(i);
          e.data = w;
          sb.push_back(e);
        end
        send_byte(w[8*k +: 8]);
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(cs ^ flip);
`else
    if (flip != 8'h00) idle(0);
`endif
    in_valid = 1'b0;
  endtask

  task automatic wait_term(input bit exp_done, input bit exp_err, input string name);
    for (int t = 0; t < 30; t++) begin
      if (done === 1'b1 || err === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (done !== exp_done || err !== exp_err) begin
      failures++;
      $display("FAIL %s_status done=%b err=%b expected done=%b err=%b", name, done, err, exp_done, exp_err);
    end
    checks++;
    if (cpu_hold !== !exp_done || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_outputs cpu_hold=%b in_ready=%b expected cpu_hold=%b in_ready=0",
               name, cpu_hold, in_ready, !exp_done);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes pending=%0d expected 0", name, sb.size());
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    gaps   = 1'b0;
    gp_idx = 0;
    sb.delete();
    words.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err} !==
        {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values in_ready=%b im_we=%b addr=%0d wdata=%h hold=%b done=%b err=%b expected 0 0 0 0 1 0 0",
               in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready in_ready=%b expected 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge in_ready=%b cpu_hold=%b expected 1 1", in_ready, cpu_hold);
    end
  endtask

  task automatic test_two_words();
    do_reset();
    words.push_back(32'h00500013);
    words.push_back(32'h00700093);
    stream_load(32'd2, 8'h00);
    wait_term(1'b1, 1'b0, "two_words");
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || im_we !== 1'b0) begin
      failures++;
      $display("FAIL done_terminal done=%b im_we=%b expected 1 0", done, im_we);
    end
  endtask

  task automatic test_reset_after_done();
    rst = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || im_addr !== '0 || im_wdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset done=%b hold=%b addr=%0d wdata=%h expected 0 1 0 0",
               done, cpu_hold, im_addr, im_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_count();
    do_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    stream_load(32'd0, 8'h00);
    wait_term(1'b1, 1'b0, "zero_count");
`else
    send_header(32'd0);
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL zero_count_next_cycle done=%b cpu_hold=%b expected 1 0", done, cpu_hold);
    end
    wait_term(1'b1, 1'b0, "zero_count");
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    send_header(32'h00000081);
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL overflow err=%b in_ready=%b cpu_hold=%b done=%b expected 1 0 1 0",
               err, in_ready, cpu_hold, done);
    end
    idle(4);
    wait_term(1'b0, 1'b1, "overflow");
  endtask

  task automatic test_full_depth();
    do_reset();
    for (int i = 0; i < (1 << ADDR_W); i++) words.push_back($urandom);
    stream_load(32'd128, 8'h00);
    wait_term(1'b1, 1'b0, "full_depth");
  endtask

  task automatic test_stall();
    do_reset();
    gaps = 1'b1;
    words.push_back(32'h00500013);
    stream_load(32'd1, 8'h00);
    wait_term(1'b1, 1'b0, "stall");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    words.push_back(32'h00500013);
    stream_load(32'd1, 8'h00);
    wait_term(1'b1, 1'b0, "csum_good");
    do_reset();
    words.push_back(32'h00500013);
    stream_load(32'd1, 8'h07);
    wait_term(1'b0, 1'b1, "csum_bad");
  endtask
`endif

  task automatic test_rst_abort();
    do_reset();
    send_header(32'd1);
    send_byte(8'h13);
    send_byte(8'h00);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (im_we !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset im_we=%b in_ready=%b expected 0 0", im_we, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    words.push_back(32'h00500013);
    stream_load(32'd1, 8'h00);
    wait_term(1'b1, 1'b0, "abort_reload");
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_two_words();
    test_reset_after_done();
    test_zero_count();
    test_overflow();
    test_full_depth();
    test_stall();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  incoming program byte is valid.
REQ-005 SHALL have port in_data  input  8  incoming program byte.
REQ-006 SHALL have port in_ready  output  1  loader accepts byte; a transfer occurs on an edge with in_valid and in_ready both high.
REQ-007 SHALL have port im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 SHALL have port im_addr  output  ADDR_W  instruction-memory word address.
REQ-009 SHALL have port im_wdata  output  32  instruction word, assembled little-endian.
REQ-010 SHALL have port cpu_hold  output  1  high keeps the CPU in reset.
REQ-011 SHALL have port done  output  1  program fully loaded.
REQ-012 SHALL have port err  output  1  load failed.

Function
REQ-013 SHALL expect the stream format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian, with an optional checksum byte (REQ-027).
REQ-014 SHALL implement states HDR, DATA, CSUM, DONE, ERR; HDR is the state after reset.
REQ-015 SHALL drive in_ready high in HDR, DATA and CSUM, and low in DONE and ERR.
REQ-016 SHALL move from HDR on the edge that accepts the 4th header byte: to ERR if N > 2^ADDR_W; to CSUM (macro defined) or DONE (macro undefined) if N = 0; otherwise to DATA.
REQ-017 SHALL, in DATA, pulse im_we high for exactly one cycle, beginning on the cycle after the 4th byte of a word is accepted, with im_wdata = {b3,b2,b1,b0} and im_addr = word index (first word at 0).
REQ-018 SHALL hold im_addr and im_wdata stable whenever im_we is low, and increment im_addr by 1 after each write.
REQ-019 SHALL move from DATA to CSUM or DONE on the edge that ends the final word's im_we pulse; no bytes are accepted during that pulse cycle.
REQ-020 SHALL stall without loss when in_valid is low for any number of cycles mid-word or mid-header; partial byte count is retained.
REQ-021 SHALL drive cpu_hold = 1 in every state except DONE, so cpu_hold falls on the first cycle state = DONE.
REQ-022 SHALL drive done = 1 only in DONE and err = 1 only in ERR; both states are terminal until rst.
REQ-023 SHALL ignore in_data whenever in_valid is low and ignore all input in DONE and ERR.

Reset
REQ-024 SHALL, while rst is high, force state HDR, in_ready 0, im_we 0, im_addr 0, im_wdata 0, cpu_hold 1, done 0, err 0, byte and word counters 0, checksum accumulator 0.
REQ-025 SHALL abort any load in progress on rst assertion, with no further im_we pulse, and restart from HDR after release.
REQ-026 SHALL drive in_ready high from the first edge after rst is released.

Configuration
REQ-027 SHALL, with macro PROG_LOADER_CHECKSUM_EN defined, accumulate the XOR of all data bytes (header excluded), accept one checksum byte in CSUM, and go to DONE if it matches or ERR if it does not.
REQ-028 SHALL, with PROG_LOADER_CHECKSUM_EN undefined, omit CSUM state and the accumulator; DATA or HDR go directly to DONE.

Structure
REQ-029 SHALL place the state enumeration, HDR_BYTES = 4 and WORD_BYTES = 4 in shared package loader_pkg.
REQ-030 SHALL instantiate one sub-module byte_packer (4-byte shift assembler with a byte counter and word_ready flag), used for both the header and the data words.

Verification
REQ-031 SHALL cover: header 02 00 00 00, bytes 13 00 50 00 93 00 70 00 -> im_we at addr 0 with 00500013, then addr 1 with 00700093; done=1; cpu_hold falls after the second write.
REQ-032 SHALL cover: header 00 00 00 00 (checksum macro undefined) -> DONE on the next cycle with no im_we pulse.
REQ-033 SHALL cover: header 81 00 00 00 with ADDR_W=7 -> ERR, err=1, in_ready=0, cpu_hold stays 1.
REQ-034 SHALL cover: one-word load with in_valid toggling 1,0,0,1,0,1,1 -> the same single write as with a gap-free stream.
REQ-035 SHALL cover (macro defined): word 00500013 with checksum 43 -> DONE; with checksum 44 -> ERR.
REQ-036 SHALL cover: rst pulsed after 2 of 4 bytes of word 1 -> no write; a fresh full stream then loads at addr 0.
